vga_fb_rect_fill: RTL

//  Hardware rectangle-fill engine: the write side of the 160x120x12 VGA framebuffer.

---
 rtl/vga_fb_rect_fill.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_fb_rect_fill.sv
// rtl/vga_fb_rect_fill.sv - rectangle-fill write engine merged with MCU pixel writes
// Define VGA_FILL_ABORT_EN to add the ABORT input that cuts a fill short.
module vga_fb_rect_fill #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120
) (
  input  logic        CLK_50MHz,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  X0,
  input  logic [7:0]  X1,
  input  logic [6:0]  Y0,
  input  logic [6:0]  Y1,
  input  logic [11:0] COLOR,
  input  logic [14:0] MCU_WA,
  input  logic [11:0] MCU_WD,
  input  logic        MCU_WE,
`ifdef VGA_FILL_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        BUSY,
  output logic        DONE,
  output logic [14:0] WA,
  output logic [11:0] WD,
  output logic        WE
);

  localparam logic [7:0] X_MAX = 8'(H_PIX - 1);
  localparam logic [6:0] Y_MAX = 7'(V_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d;
  logic [6:0]  y0_q, y0_d, y1_q, y1_d;
  logic [11:0] color_q, color_d;
  logic [7:0]  xl_q, xl_d, xr_q, xr_d, cx_q, cx_d;
  logic [6:0]  yt_q, yt_d, yb_q, yb_d, cy_q, cy_d;
  logic [14:0] wa_q, wa_d;
  logic [11:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic        abort_req;
  logic [7:0]  x_lo, x_hi;
  logic [6:0]  y_lo, y_hi;

`ifdef VGA_FILL_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign x_lo = (x0_q < x1_q) ? x0_q : x1_q;
  assign x_hi = (x0_q < x1_q) ? x1_q : x0_q;
  assign y_lo = (y0_q < y1_q) ? y0_q : y1_q;
  assign y_hi = (y0_q < y1_q) ? y1_q : y0_q;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    yt_d    = yt_q;
    yb_d    = yb_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          x0_d    = X0;
          x1_d    = X1;
          y0_d    = Y0;
          y1_d    = Y1;
          color_d = COLOR;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        xl_d    = (x_lo > X_MAX) ? X_MAX : x_lo;
        xr_d    = (x_hi > X_MAX) ? X_MAX : x_hi;
        yt_d    = (y_lo > Y_MAX) ? Y_MAX : y_lo;
        yb_d    = (y_hi > Y_MAX) ? Y_MAX : y_hi;
        cx_d    = xl_d;
        cy_d    = yt_d;
        state_d = abort_req ? S_FIN : S_FILL;
      end
      S_FILL: begin
        if (abort_req) begin
          state_d = S_FIN;
        end else if (!MCU_WE) begin
          // MCU owns the port this cycle otherwise; cursor simply holds
          we_d = 1'b1;
          wa_d = {cy_q, cx_q};
          wd_d = color_q;
          if (cx_q == xr_q) begin
            if (cy_q == yb_q) begin
              state_d = S_FIN;
            end else begin
              cx_d = xl_q;
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (MCU_WE) begin
      we_d = 1'b1;
      wa_d = MCU_WA;
      wd_d = MCU_WD;
    end
  end

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      yt_q    <= '0;
      yb_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      yt_q    <= yt_d;
      yb_q    <= yb_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
    end
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_FIN);
  assign WA   = wa_q;
  assign WD   = wd_q;
  assign WE   = we_q;

endmodule
